alu_seq_unit: RTL and testbench

//  Multi-cycle ALU execution unit with a start/done handshake; the responder that
//  the datapath control sequencer drives with RA/RB/opcode.

---
 rtl/alu_seq_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith/shift ops, iterative
// shift-add signed multiply and restoring signed divide behind a start/done handshake.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   RA,
  input  logic [WIDTH-1:0]   RB,
  output logic [2*WIDTH-1:0] RZ,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC1,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [WIDTH-1:0]     ra_q, ra_d;
  logic [WIDTH-1:0]     rb_q, rb_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rz_q, rz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic                 ill_q, ill_d;

  // Single-cycle datapath, evaluated on the latched operands.
  logic [SW-1:0]        shamt;
  logic [SW:0]          shinv;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_legal;

  assign shamt = rb_q[SW-1:0];
  assign shinv = (SW+1)'(WIDTH) - {1'b0, shamt};

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (op_q)
      OP_ADD:  alu_res = ra_q + rb_q;
      OP_SUB:  alu_res = ra_q - rb_q;
      OP_AND:  alu_res = ra_q & rb_q;
      OP_OR:   alu_res = ra_q | rb_q;
      OP_ROR:  alu_res = (ra_q >> shamt) | (ra_q << shinv);
      OP_ROL:  alu_res = (ra_q << shamt) | (ra_q >> shinv);
      OP_SHR:  alu_res = ra_q >> shamt;
      OP_SHRA: alu_res = $signed(ra_q) >>> shamt;
      OP_SHL:  alu_res = ra_q << shamt;
      OP_NEG:  alu_res = '0 - ra_q;
      OP_NOT:  alu_res = ~ra_q;
      OP_MUL:  alu_res = '0;
      OP_DIV:  alu_res = '0;
      default: alu_legal = 1'b0;
    endcase
  end

  // Magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned number.
  logic [WIDTH-1:0]     ra_mag, rb_mag;
  assign ra_mag = ra_q[WIDTH-1] ? ('0 - ra_q) : ra_q;
  assign rb_mag = rb_q[WIDTH-1] ? ('0 - rb_q) : rb_q;

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: acc = {remainder, dividend bits shifting into quotient bits}.
  logic [WIDTH:0]       div_trial, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, mcand_q};
  assign div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH-1:0]     quo_neg, rem_neg;
  assign prod_neg = '0 - acc_q;
  assign quo_neg  = '0 - acc_q[WIDTH-1:0];
  assign rem_neg  = '0 - acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    rz_d    = rz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        // The done cycle itself refuses new work; the following cycle accepts.
        if (start && !done_q) begin
          op_d   = opcode;
          ra_d   = RA;
          rb_d   = RB;
          cnt_d  = '0;
          busy_d = 1'b0;
          dbz_d  = 1'b0;
          ill_d  = 1'b0;
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
          end else if (opcode == OP_DIV && RB != '0) begin
            state_d = S_DIV;
          end else begin
            state_d = S_EXEC1;
          end
        end
      end
      S_EXEC1: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        rz_d    = {{WIDTH{1'b0}}, alu_res};
        if (op_q == OP_DIV) begin
          rz_d  = '0;
          dbz_d = 1'b1;
        end else if (!alu_legal) begin
          rz_d  = '0;
          ill_d = 1'b1;
        end
      end
      S_MUL, S_DIV: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          neg_d  = ra_q[WIDTH-1] ^ rb_q[WIDTH-1];
          rneg_d = ra_q[WIDTH-1];
          if (state_q == S_MUL) begin
            mcand_d = ra_mag;
            acc_d   = {{WIDTH{1'b0}}, rb_mag};
          end else begin
            mcand_d = rb_mag;
            acc_d   = {{WIDTH{1'b0}}, ra_mag};
          end
        end else begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q == OP_MUL) begin
          rz_d = neg_q ? prod_neg : acc_q;
        end else begin
          rz_d = {(rneg_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH]),
                  (neg_q  ? quo_neg : acc_q[WIDTH-1:0])};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      rz_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      rz_q    <= rz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  assign RZ          = rz_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit plus hand sequences for
// start-while-busy, start-during-done, reset abort and reset-beats-start.
module tb_alu_seq_unit;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BAD  = 5'b11111;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  opcode;
  logic [31:0] RA, RB;
  logic [63:0] RZ;
  logic        busy, done, div_by_zero, illegal_op;

  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .RA(RA), .RB(RB), .RZ(RZ), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rz;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(string n, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                               logic [63:0] z, logic dz, logic il, int lat);
    vec_t v;
    v.name = n; v.op = op; v.ra = a; v.rb = b; v.rz = z; v.dbz = dz; v.ill = il; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic chk64(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic chkint(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs after accept, and measure latency
  // (accept edge = cycle 0) and the number of sampled cycles with busy high.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] rz_o, output logic dbz_o, output logic ill_o,
                        output int lat_o, output int busy_o);
    @(negedge clk);
    start = 1'b1; opcode = op; RA = a; RB = b;
    @(posedge clk);
    lat_o = 0; busy_o = 0;
    @(negedge clk);
    start = 1'b0; opcode = OP_ADD; RA = $urandom; RB = $urandom;
    while (!done && lat_o < LIMIT) begin
      if (busy) busy_o++;
      @(negedge clk);
      lat_o++;
    end
    if (busy) busy_o++;
    if (lat_o >= LIMIT) $display("FAIL timeout: no done within %0d cycles", LIMIT);
    rz_o = RZ; dbz_o = div_by_zero; ill_o = illegal_op;
  endtask

  logic [63:0] g_rz;
  logic        g_dbz, g_ill;
  int          g_lat, g_busy, c, dones;
  logic        found;

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; RA = '0; RB = '0;

    addv("add",        OP_ADD,  32'd8,        32'd8,        64'd16,                  0, 0, 1);
    addv("add_wrap",   OP_ADD,  32'hFFFFFFFF, 32'd1,        64'd0,                   0, 0, 1);
    addv("sub",        OP_SUB,  32'hFFFFFFF8, 32'd8,        64'h00000000_FFFFFFF0,   0, 0, 1);
    addv("shra",       OP_SHRA, 32'h80000000, 32'd4,        64'h00000000_F8000000,   0, 0, 1);
    addv("and",        OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000,   0, 0, 1);
    addv("or",         OP_OR,   32'h0F0F0000, 32'h000000F0, 64'h00000000_0F0F00F0,   0, 0, 1);
    addv("ror8",       OP_ROR,  32'h12345678, 32'd8,        64'h00000000_78123456,   0, 0, 1);
    addv("ror0",       OP_ROR,  32'h12345678, 32'd0,        64'h00000000_12345678,   0, 0, 1);
    addv("rol4",       OP_ROL,  32'h12345678, 32'd4,        64'h00000000_23456781,   0, 0, 1);
    addv("shr31",      OP_SHR,  32'h80000000, 32'd31,       64'd1,                   0, 0, 1);
    addv("shl31",      OP_SHL,  32'h00000001, 32'd31,       64'h00000000_80000000,   0, 0, 1);
    addv("shl_cnt32",  OP_SHL,  32'h0000ABCD, 32'h00000020, 64'h00000000_0000ABCD,   0, 0, 1);
    addv("neg_min",    OP_NEG,  32'h80000000, 32'd0,        64'h00000000_80000000,   0, 0, 1);
    addv("neg1",       OP_NEG,  32'd1,        32'd0,        64'h00000000_FFFFFFFF,   0, 0, 1);
    addv("not",        OP_NOT,  32'd0,        32'd0,        64'h00000000_FFFFFFFF,   0, 0, 1);
    addv("mul_nn",     OP_MUL,  32'hFFFFFFF8, 32'hFFFFFFF8, 64'd64,                  0, 0, 34);
    addv("mul_max2",   OP_MUL,  32'h7FFFFFFF, 32'd2,        64'h00000000_FFFFFFFE,   0, 0, 34);
    addv("mul_minmin", OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000,   0, 0, 34);
    addv("mul_neg",    OP_MUL,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1,   0, 0, 34);
    addv("div",        OP_DIV,  32'd36,       32'd6,        64'h00000000_00000006,   0, 0, 34);
    addv("div_negA",   OP_DIV,  32'hFFFFFFDB, 32'd6,        64'hFFFFFFFF_FFFFFFFA,   0, 0, 34);
    addv("div_negB",   OP_DIV,  32'd37,       32'hFFFFFFFA, 64'h00000001_FFFFFFFA,   0, 0, 34);
    addv("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000,   0, 0, 34);
    addv("div_zero",   OP_DIV,  32'd5,        32'd0,        64'd0,                   1, 0, 1);
    addv("add_clr",    OP_ADD,  32'd1,        32'd1,        64'd2,                   0, 0, 1);
    addv("illegal",    OP_BAD,  32'h1234,     32'h5678,     64'd0,                   0, 1, 1);
    addv("add_clr2",   OP_ADD,  32'd3,        32'd4,        64'd7,                   0, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk64("reset_rz", RZ, 64'd0);
    chkint("reset_busy", int'(busy), 0);
    chkint("reset_done", int'(done), 0);
    chkint("reset_dbz", int'(div_by_zero), 0);
    chkint("reset_ill", int'(illegal_op), 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].ra, vecs[i].rb, g_rz, g_dbz, g_ill, g_lat, g_busy);
      $display("tx %-10s op=%b ra=%h rb=%h rz=%h dbz=%0d ill=%0d lat=%0d busy_cycles=%0d",
               vecs[i].name, vecs[i].op, vecs[i].ra, vecs[i].rb, g_rz, g_dbz, g_ill, g_lat, g_busy);
      chk64({vecs[i].name, "_rz"}, g_rz, vecs[i].rz);
      chkint({vecs[i].name, "_dbz"}, int'(g_dbz), int'(vecs[i].dbz));
      chkint({vecs[i].name, "_ill"}, int'(g_ill), int'(vecs[i].ill));
      chkint({vecs[i].name, "_lat"}, g_lat, vecs[i].lat);
      chkint({vecs[i].name, "_busy"}, g_busy, (vecs[i].lat > 1) ? vecs[i].lat - 1 : 0);
    end

    // MUL -8*3 with a stray add request in cycle 5 and another during the done cycle.
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; RA = 32'hFFFFFFF8; RB = 32'd3;
    @(posedge clk);
    c = 0; found = 1'b0;
    while (c < LIMIT && !found) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 5) begin start = 1'b1; opcode = OP_ADD; RA = 32'd1; RB = 32'd1; end
      if (c == 6) start = 1'b0;
      if (done) found = 1'b1;
      else c++;
    end
    $display("tx mul_ignore rz=%h lat=%0d", RZ, c);
    chkint("ignore_lat", c, 34);
    chk64("ignore_rz", RZ, 64'hFFFFFFFF_FFFFFFE8);
    start = 1'b1; opcode = OP_NOT; RA = 32'd0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
    end
    $display("tx start_in_done dones=%0d rz=%h", dones, RZ);
    chkint("done_cycle_start_ignored", dones, 0);
    chk64("done_cycle_rz_hold", RZ, 64'hFFFFFFFF_FFFFFFE8);

    // Reset in cycle 10 of a MUL aborts it without a done.
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; RA = 32'd5; RB = 32'd7;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chkint("busy_before_abort", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkint("abort_busy", int'(busy), 0);
    chkint("abort_done", int'(done), 0);
    chk64("abort_rz", RZ, 64'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    $display("tx mul_abort dones_after=%0d busy=%0d", dones, busy);
    chkint("abort_no_done", dones, 0);

    // Reset and start together: reset wins, no request is taken.
    start = 1'b1; opcode = OP_ADD; RA = 32'd1; RB = 32'd1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chkint("rst_start_done0", int'(done), 0);
    @(negedge clk);
    $display("tx reset_and_start done=%0d rz=%h", done, RZ);
    chkint("rst_start_done1", int'(done), 0);
    chk64("rst_start_rz", RZ, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
